// File: rtl/aes_dec_key_gen_pkg.sv
// Shared AES-128 key-schedule definitions: widths, round count, Rcon start value
// and the GF(2^8) helpers used by the schedule step.
package aes_dec_key_gen_pkg;

    localparam int AES_NR = 10;
    localparam int KEY_W = 128;
    localparam int WORD_W = 32;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_dec_key_gen_if.sv
// Key-delivery bus between the key source, the schedule engine and AES_DEC.
interface aes_dec_key_gen_if;
    import aes_dec_key_gen_pkg::*;

    logic EN;
    key_t Key;
    logic Krdy;
    key_t Kout;
    logic Kvld;
    logic BSY;

    modport master (
        output EN,
        output Key,
        output Krdy,
        input  Kout,
        input  Kvld,
        input  BSY
    );

    modport slave (
        input  EN,
        input  Key,
        input  Krdy,
        output Kout,
        output Kvld,
        output BSY
    );

endinterface

// File: rtl/aes_dec_key_gen_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_dec_key_gen_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Row 0 sits in the most significant bits, so entry a lives at slot 255-a (= ~a).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    assign bit_idx = {~a, 3'b000};
    assign y = SBOX[bit_idx +: 8];

endmodule

// File: rtl/aes_dec_key_gen.sv
// Iterative AES-128 key schedule: one round key per clock, presents the
// round-ROUNDS key (the AES_DEC decryption key) on Kout with a one-cycle Kvld.
module aes_dec_key_gen
    import aes_dec_key_gen_pkg::*;
#(
    parameter int ROUNDS = AES_NR
) (
    input logic CLK,
    input logic RST,
    aes_dec_key_gen_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_t state;
    logic [3:0] rnd;
    logic [7:0] rcon;
    logic bsy;
    logic kvld;
    key_t kout;
    key_t wkey;
    key_t next_key;
    logic accept;

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, t;
    word_t n0, n1, n2, n3;

    assign accept = bus.Krdy && bus.EN && !bsy;

    // One schedule step on the working key.
    assign {w0, w1, w2, w3} = wkey;
    assign rot_w = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_dec_key_gen_sbox u_sbox (
            .a(rot_w[8*i +: 8]),
            .y(sub_w[8*i +: 8])
        );
    end

    assign t  = sub_w ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Control and the visible outputs; EN only gates acceptance, never stalls a run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            rnd   <= 4'd0;
            rcon  <= RCON_INIT;
            bsy   <= 1'b0;
            kvld  <= 1'b0;
            kout  <= '0;
        end else begin
            kvld <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        rnd   <= 4'd0;
                        rcon  <= RCON_INIT;
                        bsy   <= 1'b1;
                    end
                end
                RUN: begin
                    rcon <= xtime(rcon);
                    rnd  <= rnd + 4'd1;
                    if (rnd == LAST_RND) begin
                        state <= IDLE;
                        rnd   <= 4'd0;
                        bsy   <= 1'b0;
                        kvld  <= 1'b1;
                        kout  <= next_key;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working key is pure data; control decides when it is meaningful.
    always_ff @(posedge CLK) begin
        if (accept) begin
            wkey <= bus.Key;
        end else if (state == RUN) begin
            wkey <= next_key;
        end
    end

    assign bus.Kout = kout;
    assign bus.Kvld = kvld;
    assign bus.BSY  = bsy;

endmodule

// File: tb/tb_aes_dec_key_gen.sv
// Self-checking bench for aes_dec_key_gen (ROUNDS=10 and a ROUNDS=1 debug build).
module tb_aes_dec_key_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;

    aes_dec_key_gen_if bus ();
    aes_dec_key_gen_if bus1 ();

    aes_dec_key_gen #(.ROUNDS(10)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    aes_dec_key_gen #(.ROUNDS(1))  dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    always #5 CLK = ~CLK;

    // ---------------- reference model from GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] key, input int n);
        logic [31:0] w [4];
        logic [31:0] tmp;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int r = 0; r < n; r++) begin
            tmp = {w[3][23:0], w[3][31:24]};
            for (int b = 0; b < 4; b++) tmp[8*b +: 8] = sbox_ref(tmp[8*b +: 8]);
            tmp = tmp ^ {rc, 24'h0};
            w[0] = w[0] ^ tmp;
            for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
            rc = gmul(rc, 8'h02);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking inside) ----------------
    // Present a key for exactly one accept edge; returns at the falling edge after it.
    task automatic start_key(input logic [127:0] k);
        @(negedge CLK);
        bus.Key = k; bus.Krdy = 1'b1; bus.EN = 1'b1;
        @(negedge CLK);
        bus.Krdy = 1'b0; bus.Key = rand_key();
    endtask

    task automatic observe(input int ncyc, output int bsy_n, output int vld_first,
                           output int vld_n, output logic [127:0] kout_at_vld);
        bsy_n = 0; vld_first = -1; vld_n = 0; kout_at_vld = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (bus.BSY) bsy_n++;
            if (bus.Kvld) begin
                vld_n++;
                if (vld_first < 0) begin
                    vld_first = c;
                    kout_at_vld = bus.Kout;
                end
            end
            @(negedge CLK);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++; if (bus.Kout !== 128'h0) begin failures++; $display("FAIL reset_kout got=%h exp=0", bus.Kout); end
        checks++; if (bus.Kvld !== 1'b0) begin failures++; $display("FAIL reset_kvld got=%b exp=0", bus.Kvld); end
        checks++; if (bus.BSY !== 1'b0) begin failures++; $display("FAIL reset_bsy got=%b exp=0", bus.BSY); end
        checks++; if (bus1.Kout !== 128'h0) begin failures++; $display("FAIL reset_kout1 got=%h exp=0", bus1.Kout); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.BSY !== 1'b0 || bus.Kvld !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=00", bus.BSY, bus.Kvld); end
    endtask

    task automatic test_kat();
        logic [127:0] keys [3] = '{128'h000102030405060708090a0b0c0d0e0f,
                                   128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        logic [127:0] exps [3] = '{128'h13111d7fe3944a17f307a78b4d2b30c5,
                                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                                   128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        int bn, vf, vn;
        logic [127:0] ko;
        for (int i = 0; i < 3; i++) begin
            start_key(keys[i]);
            observe(14, bn, vf, vn, ko);
            checks++; if (ko !== exps[i]) begin failures++; $display("FAIL kat%0d_kout got=%h exp=%h", i, ko, exps[i]); end
            checks++; if (bn != 10) begin failures++; $display("FAIL kat%0d_bsy_cycles got=%0d exp=10", i, bn); end
            checks++; if (vf != 10) begin failures++; $display("FAIL kat%0d_latency got=%0d exp=10", i, vf); end
            checks++; if (vn != 1) begin failures++; $display("FAIL kat%0d_pulses got=%0d exp=1", i, vn); end
            checks++; if (bus.Kout !== exps[i]) begin failures++; $display("FAIL kat%0d_hold got=%h exp=%h", i, bus.Kout, exps[i]); end
        end
    endtask

    task automatic test_random();
        int bn, vf, vn;
        logic [127:0] k, ko;
        for (int i = 0; i < 6; i++) begin
            k = rand_key();
            start_key(k);
            observe(12, bn, vf, vn, ko);
            checks++; if (ko !== expand(k, 10) || vf != 10) begin
                failures++; $display("FAIL rand%0d got=%h@%0d exp=%h@10", i, ko, vf, expand(k, 10));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int bn = 0, vn = 0;
        logic [127:0] k1 = rand_key();
        logic [127:0] k2 = rand_key();
        logic [127:0] ko = '0;
        start_key(k1);
        for (int c = 0; c < 16; c++) begin
            if (c == 3) begin bus.Krdy = 1'b1; bus.Key = k2; end
            if (c == 6) bus.Krdy = 1'b0;
            if (bus.BSY) bn++;
            if (bus.Kvld) begin vn++; ko = bus.Kout; end
            @(negedge CLK);
        end
        checks++; if (ko !== expand(k1, 10)) begin failures++; $display("FAIL busy_kout got=%h exp=%h", ko, expand(k1, 10)); end
        checks++; if (vn != 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", vn); end
        checks++; if (bn != 10) begin failures++; $display("FAIL busy_no_queue got=%0d exp=10", bn); end
    endtask

    task automatic test_en();
        int bn = 0, vn = 0, vf = -1;
        logic [127:0] k = rand_key();
        logic [127:0] ko = '0;
        @(negedge CLK);
        bus.EN = 1'b0; bus.Krdy = 1'b1; bus.Key = k;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bus.BSY) bn++;
            if (bus.Kvld) vn++;
        end
        bus.Krdy = 1'b0; bus.EN = 1'b1;
        checks++; if (bn != 0 || vn != 0) begin failures++; $display("FAIL en_low_accept got=bsy%0d/vld%0d exp=0/0", bn, vn); end
        start_key(k);
        for (int c = 0; c < 14; c++) begin
            if (c == 2) bus.EN = 1'b0;
            if (bus.Kvld && vf < 0) begin vf = c; ko = bus.Kout; end
            @(negedge CLK);
        end
        bus.EN = 1'b1;
        checks++; if (vf != 10 || ko !== expand(k, 10)) begin
            failures++; $display("FAIL en_drop_mid got=%h@%0d exp=%h@10", ko, vf, expand(k, 10));
        end
    endtask

    task automatic test_reset_abort();
        int bn, vf, vn;
        logic [127:0] ko;
        logic [127:0] k = rand_key();
        start_key(rand_key());
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (bus.Kout !== 128'h0 || bus.Kvld !== 1'b0 || bus.BSY !== 1'b0) begin
            failures++; $display("FAIL abort_outputs got=%h/%b/%b exp=0/0/0", bus.Kout, bus.Kvld, bus.BSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        observe(15, bn, vf, vn, ko);
        checks++; if (vn != 0 || bn != 0) begin failures++; $display("FAIL abort_no_kvld got=vld%0d/bsy%0d exp=0/0", vn, bn); end
        start_key(k);
        observe(14, bn, vf, vn, ko);
        checks++; if (vf != 10 || ko !== expand(k, 10) || vn != 1) begin
            failures++; $display("FAIL abort_recover got=%h@%0d n=%0d exp=%h@10 n=1", ko, vf, vn, expand(k, 10));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1 = rand_key();
        logic [127:0] k2 = rand_key();
        logic bsy_c [25];
        logic vld_c [25];
        logic [127:0] ko_c [25];
        int vn = 0;
        @(negedge CLK);
        bus.EN = 1'b1; bus.Key = k1; bus.Krdy = 1'b1;
        @(negedge CLK);
        bus.Key = k2;
        for (int c = 0; c < 25; c++) begin
            bsy_c[c] = bus.BSY; vld_c[c] = bus.Kvld; ko_c[c] = bus.Kout;
            if (c <= 21 && bus.Kvld) vn++;
            @(negedge CLK);
        end
        bus.Krdy = 1'b0;
        checks++; if (vld_c[10] !== 1'b1 || ko_c[10] !== expand(k1, 10)) begin
            failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", vld_c[10], ko_c[10], expand(k1, 10));
        end
        checks++; if (bsy_c[10] !== 1'b0 || bsy_c[11] !== 1'b1) begin
            failures++; $display("FAIL b2b_reaccept got=%b%b exp=01", bsy_c[10], bsy_c[11]);
        end
        checks++; if (ko_c[15] !== expand(k1, 10)) begin failures++; $display("FAIL b2b_kout_hold got=%h exp=%h", ko_c[15], expand(k1, 10)); end
        checks++; if (vld_c[21] !== 1'b1 || ko_c[21] !== expand(k2, 10)) begin
            failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", vld_c[21], ko_c[21], expand(k2, 10));
        end
        checks++; if (vn != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", vn); end
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_rounds1();
        logic [127:0] keys [2];
        logic [127:0] exps [2];
        int bn, vf;
        logic [127:0] ko;
        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        exps[0] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        keys[1] = rand_key();
        exps[1] = expand(keys[1], 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            bus1.Key = keys[i]; bus1.Krdy = 1'b1; bus1.EN = 1'b1;
            @(negedge CLK);
            bus1.Krdy = 1'b0;
            bn = 0; vf = -1; ko = '0;
            for (int c = 0; c < 4; c++) begin
                if (bus1.BSY) bn++;
                if (bus1.Kvld && vf < 0) begin vf = c; ko = bus1.Kout; end
                @(negedge CLK);
            end
            checks++; if (ko !== exps[i] || vf != 1) begin failures++; $display("FAIL r1_%0d got=%h@%0d exp=%h@1", i, ko, vf, exps[i]); end
            checks++; if (bn != 1) begin failures++; $display("FAIL r1_%0d_bsy got=%0d exp=1", i, bn); end
        end
    endtask

    initial begin
        bus.EN = 1'b0; bus.Krdy = 1'b0; bus.Key = '0;
        bus1.EN = 1'b0; bus1.Krdy = 1'b0; bus1.Key = '0;
        test_reset();
        test_kat();
        test_random();
        test_busy_ignore();
        test_en();
        test_reset_abort();
        test_back_to_back();
        test_rounds1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
